// File: rtl/ts_gen_mlane_pkg.sv
// rtl/ts_gen_mlane_pkg.sv - shared symbols and state encodings for the multi-lane TS generator
package ts_gen_mlane_pkg;

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] PADG12    = 8'hF7;
  localparam logic [7:0] TS1_IDTFR = 8'h4A;
  localparam logic [7:0] TS2_IDTFR = 8'h45;
  localparam logic [7:0] N_FTS     = 8'hFF;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TX       = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  function automatic logic [7:0] ident_sym(input logic ts_type);
    return ts_type ? TS2_IDTFR : TS1_IDTFR;
  endfunction

endpackage

// File: rtl/ts_lane_fmt.sv
// rtl/ts_lane_fmt.sv - combinational 16-symbol TS1/TS2 formatter for one lane
module ts_lane_fmt
  import ts_gen_mlane_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE      = 0
) (
  input  logic         ts_type,
  input  logic [7:0]   link_num,
  input  logic         link_pad,
  input  logic         lane_pad,
  input  logic         lane_reverse,
  input  logic [5:0]   rate_support,
  input  logic [7:0]   train_ctrl,
  output logic [127:0] ts
);

  localparam logic [7:0] LANE_FWD = 8'(LANE);
  localparam logic [7:0] LANE_REV = 8'(NUM_LANES - 1 - LANE);

  logic [7:0] sym1;
  logic [7:0] sym2;
  logic [7:0] ident;

  assign sym1  = link_pad ? PADG12 : link_num;
  assign sym2  = lane_pad ? PADG12 : (lane_reverse ? LANE_REV : LANE_FWD);
  assign ident = ident_sym(ts_type);

  // Symbol 0 occupies the top byte.
  assign ts = {COM, sym1, sym2, N_FTS, {2'b00, rate_support}, train_ctrl, {10{ident}}};

endmodule

// File: rtl/ts_gen_mlane.sv
// rtl/ts_gen_mlane.sv - multi-lane TS1/TS2 generator with counted, boundary-aligned config reloads
module ts_gen_mlane
  import ts_gen_mlane_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ts_update,
  output logic                   ts_update_ack,
  input  logic                   ts_type,
  input  logic [7:0]             link_num,
  input  logic                   link_pad,
  input  logic [NUM_LANES-1:0]   lane_pad_mask,
  input  logic                   lane_reverse,
  input  logic [5:0]             rate_support,
  input  logic [7:0]             train_ctrl,
  input  logic [CNT_W-1:0]       target_cnt,
  input  logic                   ts_stop,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [128*NUM_LANES-1:0] ts,
  output logic [CNT_W-1:0]       ts_cnt,
  output logic                   ts_sent_enough
);

  logic [1:0]           state;
  logic                 cfg_type;
  logic [7:0]           cfg_link;
  logic                 cfg_link_pad;
  logic [NUM_LANES-1:0] cfg_mask;
  logic                 cfg_rev;
  logic [5:0]           cfg_rate;
  logic [7:0]           cfg_ctrl;
  logic [CNT_W-1:0]     cfg_target;

  logic                 transfer;
  logic                 upd_req;
  logic                 load;
  logic [CNT_W-1:0]     cnt_next;
  logic [128*NUM_LANES-1:0] fmt_bus;

  assign transfer = ts_valid & ts_ready;
  // A request seen during its own ack cycle is stale and must not retrigger.
  assign upd_req  = ts_update & ~ts_update_ack;
  assign load     = upd_req & ~ts_stop & ((state == IDLE) | ((state == TX) & ts_ready));
  assign cnt_next = (transfer && ts_cnt != {CNT_W{1'b1}}) ? ts_cnt + CNT_W'(1) : ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      ts_valid       <= 1'b0;
      ts_update_ack  <= 1'b0;
      ts_cnt         <= '0;
      ts_sent_enough <= 1'b0;
      cfg_type       <= 1'b0;
      cfg_link       <= '0;
      cfg_link_pad   <= 1'b0;
      cfg_mask       <= '0;
      cfg_rev        <= 1'b0;
      cfg_rate       <= '0;
      cfg_ctrl       <= '0;
      cfg_target     <= '0;
    end else begin
      ts_update_ack <= 1'b0;
      if (load) begin
        state          <= TX;
        ts_valid       <= 1'b1;
        ts_update_ack  <= 1'b1;
        ts_cnt         <= '0;
        ts_sent_enough <= 1'b0;
        cfg_type       <= ts_type;
        cfg_link       <= link_num;
        cfg_link_pad   <= link_pad;
        cfg_mask       <= lane_pad_mask;
        cfg_rev        <= lane_reverse;
        cfg_rate       <= rate_support;
        cfg_ctrl       <= train_ctrl;
        cfg_target     <= target_cnt;
      end else begin
        case (state)
          TX: begin
            ts_cnt         <= cnt_next;
            ts_sent_enough <= (cnt_next >= cfg_target);
            if (ts_stop) begin
              if (ts_ready) begin
                state    <= IDLE;
                ts_valid <= 1'b0;
              end else begin
                state <= STOPPING;
              end
            end
          end
          STOPPING: begin
            ts_cnt         <= cnt_next;
            ts_sent_enough <= (cnt_next >= cfg_target);
            if (ts_ready) begin
              state    <= IDLE;
              ts_valid <= 1'b0;
            end
          end
          default: begin
            state          <= IDLE;
            ts_valid       <= 1'b0;
            ts_sent_enough <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ts_lane_fmt #(
      .NUM_LANES (NUM_LANES),
      .LANE      (i)
    ) u_fmt (
      .ts_type      (cfg_type),
      .link_num     (cfg_link),
      .link_pad     (cfg_link_pad),
      .lane_pad     (cfg_mask[i]),
      .lane_reverse (cfg_rev),
      .rate_support (cfg_rate),
      .train_ctrl   (cfg_ctrl),
      .ts           (fmt_bus[128*i +: 128])
    );
  end

  assign ts = ts_valid ? fmt_bus : '0;

endmodule
